// File: rtl/auxrx_fifo.sv
// auxrx_fifo: receive-side FIFO for an auxiliary UART, exposed on a
// single-cycle Wishbone-style slave port with two registers.
//
// Ports
//   i_clk, i_rst            clock (rising edge) and async active-high reset
//   i_rx_stb                one-cycle strobe: received byte + flags valid
//   i_rx_data[7:0]          received byte
//   i_rx_break/perr/ferr    line break, parity error, framing error flags
//   i_wb_stb, i_wb_we       bus strobe and write enable
//   i_wb_addr               0 = data register (read pops), 1 = status/control
//   i_wb_data[31:0]         bus write data (status: bit0 clears overflow,
//                           bit1 flushes the FIFO)
//   o_wb_ack                acknowledge, one cycle after every strobe
//   o_wb_stall              tied low, the slave never stalls
//   o_wb_data[31:0]         registered read data, valid with o_wb_ack
//   o_rts                   high while fill < RTS_LEVEL
//   o_int                   FIFO not empty
//   o_half_int              fill >= half depth
//
// Data read word  : {20'h0, break, ferr, perr, empty, data[7:0]}
// Status read word: {16'h0, overflow, 2'b0, half, empty, 0.., fill}
module auxrx_fifo #(
    parameter int unsigned LGFLEN    = 4,
    parameter int unsigned RTS_LEVEL = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_stb,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_break,
    input  logic        i_rx_perr,
    input  logic        i_rx_ferr,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic        i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    output logic        o_rts,
    output logic        o_int,
    output logic        o_half_int
);

    localparam int unsigned DEPTH = 1 << LGFLEN;
    localparam int unsigned FW    = LGFLEN + 1;
    localparam int unsigned PW    = LGFLEN;

    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
    localparam logic [FW-1:0] FILL_HALF = FW'(DEPTH / 2);
    localparam logic [FW-1:0] FILL_RTS  = FW'(RTS_LEVEL);

    // One stored receive event
    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [FW-1:0]   fill;
    logic            overflow;

    logic            rd_req_c;
    logic            ctl_wr_c;
    logic            flush_c;
    logic            ovf_clr_c;
    logic            empty_c;
    logic            full_c;
    logic            half_c;
    logic            pop_c;
    logic            push_c;
    logic            drop_c;
    entry_t          head_c;
    entry_t          rx_entry_c;
    logic [31:0]     rd_word_c;

    // Upper write-data bits carry no control function
    logic            unused_wb_data;
    assign unused_wb_data = ^i_wb_data[31:2];

    assign o_wb_stall = 1'b0;

    // Transfer decode
    always_comb begin
        rd_req_c   = i_wb_stb & ~i_wb_we & ~i_wb_addr;
        ctl_wr_c   = i_wb_stb & i_wb_we & i_wb_addr;
        flush_c    = ctl_wr_c & i_wb_data[1];
        ovf_clr_c  = ctl_wr_c & i_wb_data[0];
        empty_c    = (fill == '0);
        full_c     = (fill == FILL_FULL);
        half_c     = (fill >= FILL_HALF);
        pop_c      = rd_req_c & ~empty_c;
        // A pop in the same cycle frees the slot a full FIFO needs; a flush
        // discards any concurrent push outright.
        push_c     = i_rx_stb & ~flush_c & (~full_c | pop_c);
        drop_c     = i_rx_stb & ~flush_c & full_c & ~pop_c;
        head_c     = mem[rd_ptr];
        rx_entry_c = '{brk: i_rx_break, ferr: i_rx_ferr, perr: i_rx_perr, data: i_rx_data};
    end

    // Read word mux; an empty data read reports only the empty bit
    always_comb begin
        rd_word_c = '0;
        if (i_wb_addr) begin
            rd_word_c[15]     = overflow;
            rd_word_c[12]     = half_c;
            rd_word_c[11]     = empty_c;
            rd_word_c[FW-1:0] = fill;
        end else begin
            rd_word_c[8] = empty_c;
            if (!empty_c) begin
                rd_word_c[11]  = head_c.brk;
                rd_word_c[10]  = head_c.ferr;
                rd_word_c[9]   = head_c.perr;
                rd_word_c[7:0] = head_c.data;
            end
        end
    end

    // Storage array, not reset
    always_ff @(posedge i_clk) begin
        if (push_c) begin
            mem[wr_ptr] <= rx_entry_c;
        end
    end

    // Pointers and fill count
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (flush_c) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Sticky overflow; a new drop wins over a clear in the same cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end else if (ovf_clr_c) begin
            overflow <= 1'b0;
        end
    end

    // Bus response; read data only updates on read strobes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack <= i_wb_stb;
            if (i_wb_stb && !i_wb_we) begin
                o_wb_data <= rd_word_c;
            end
        end
    end

    // Level outputs sampled from the fill count held before this edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_int      <= 1'b0;
            o_half_int <= 1'b0;
            o_rts      <= 1'b1;
        end else begin
            o_int      <= ~empty_c;
            o_half_int <= half_c;
            o_rts      <= (fill < FILL_RTS);
        end
    end

endmodule

// File: tb/tb_auxrx_fifo.sv
// Self-checking bench for auxrx_fifo with a queue-based reference model.
module tb_auxrx_fifo;

    localparam int unsigned LGFLEN    = 4;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned RTS_LEVEL = 12;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_rx_stb;
    logic [7:0]  i_rx_data;
    logic        i_rx_break;
    logic        i_rx_perr;
    logic        i_rx_ferr;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic        i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;
    logic        o_rts;
    logic        o_int;
    logic        o_half_int;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [10:0] mq[$];
    logic        m_ovf;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        m_int;
    logic        m_half;
    logic        m_rts;

    auxrx_fifo #(.LGFLEN(LGFLEN), .RTS_LEVEL(RTS_LEVEL)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx_stb   (i_rx_stb),
        .i_rx_data  (i_rx_data),
        .i_rx_break (i_rx_break),
        .i_rx_perr  (i_rx_perr),
        .i_rx_ferr  (i_rx_ferr),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .o_wb_ack   (o_wb_ack),
        .o_wb_stall (o_wb_stall),
        .o_wb_data  (o_wb_data),
        .o_rts      (o_rts),
        .o_int      (o_int),
        .o_half_int (o_half_int)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_ack   = 1'b0;
        m_rdata = 32'h0;
        m_int   = 1'b0;
        m_half  = 1'b0;
        m_rts   = 1'b1;
    endtask

    // One clock edge of the behavioural model
    task automatic model_step(input logic rs, input logic [10:0] ent, input logic ws,
                              input logic we, input logic wa, input logic [31:0] wd);
        int          n;
        logic [31:0] dat;
        logic [31:0] stat;
        logic [10:0] e;
        logic        popped;
        n   = mq.size();
        dat = 32'h100;
        if (n > 0) begin
            e   = mq[0];
            dat = {20'h0, e[10:8], 1'b0, e[7:0]};
        end
        stat = {16'h0, m_ovf, 2'b00, 1'(n >= int'(DEPTH / 2)), 1'(n == 0), 11'(n)};
        m_ack = ws;
        if (ws && !we) m_rdata = wa ? stat : dat;
        m_int  = (n != 0);
        m_half = (n >= int'(DEPTH / 2));
        m_rts  = (n < int'(RTS_LEVEL));
        popped = ws && !we && !wa && (n > 0);
        if (ws && we && wa && wd[1]) begin
            mq.delete();
        end else begin
            if (popped) void'(mq.pop_front());
            if (rs) begin
                if (n < int'(DEPTH) || popped) mq.push_back(ent);
                else m_ovf = 1'b1;
            end
        end
        if (ws && we && wa && wd[0] && !(rs && n == int'(DEPTH) && !popped && !wd[1]))
            m_ovf = 1'b0;
    endtask

    // Advance one clock with the currently driven inputs, then idle the strobes
    task automatic cyc();
        logic        rs;
        logic [10:0] ent;
        logic        ws;
        logic        we;
        logic        wa;
        logic [31:0] wd;
        rs  = i_rx_stb;
        ent = {i_rx_break, i_rx_ferr, i_rx_perr, i_rx_data};
        ws  = i_wb_stb;
        we  = i_wb_we;
        wa  = i_wb_addr;
        wd  = i_wb_data;
        @(posedge i_clk);
        #1;
        model_step(rs, ent, ws, we, wa, wd);
        i_rx_stb   = 1'b0;
        i_rx_break = 1'b0;
        i_rx_ferr  = 1'b0;
        i_rx_perr  = 1'b0;
        i_wb_stb   = 1'b0;
        i_wb_we    = 1'b0;
    endtask

    task automatic set_push(input logic [7:0] b);
        i_rx_stb  = 1'b1;
        i_rx_data = b;
    endtask

    task automatic set_bus(input logic we, input logic addr, input logic [31:0] wd);
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = wd;
    endtask

    task automatic drain();
        int guard = 0;
        while (mq.size() > 0 && guard < 64) begin
            set_bus(1'b0, 1'b0, 32'h0);
            cyc();
            guard++;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checks++; if (o_wb_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", o_wb_ack); end
        checks++; if (o_wb_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", o_wb_data); end
        checks++; if (o_int !== 1'b0) begin errors++; $display("FAIL reset_int got=%b exp=0", o_int); end
        checks++; if (o_half_int !== 1'b0) begin errors++; $display("FAIL reset_half got=%b exp=0", o_half_int); end
        checks++; if (o_rts !== 1'b1) begin errors++; $display("FAIL reset_rts got=%b exp=1", o_rts); end
        checks++; if (o_wb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", o_wb_stall); end
        model_reset();
        i_rst = 1'b0;
    endtask

    task automatic test_fifo_order();
        logic [31:0] exp_w [4] = '{32'h041, 32'h042, 32'h043, 32'h100};
        for (int b = 0; b < 3; b++) begin
            set_push(8'h41 + 8'(b));
            cyc();
        end
        for (int k = 0; k < 4; k++) begin
            set_bus(1'b0, 1'b0, 32'h0);
            cyc();
            checks++; if (o_wb_ack !== 1'b1) begin errors++; $display("FAIL order_ack[%0d] got=%b exp=1", k, o_wb_ack); end
            checks++; if (o_wb_data !== exp_w[k]) begin errors++; $display("FAIL order_data[%0d] got=%h exp=%h", k, o_wb_data, exp_w[k]); end
            checks++; if (o_int !== (k < 3)) begin errors++; $display("FAIL order_int[%0d] got=%b exp=%b", k, o_int, (k < 3)); end
        end
        cyc();
        checks++; if (o_wb_ack !== 1'b0) begin errors++; $display("FAIL order_ack_idle got=%b exp=0", o_wb_ack); end
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [17];
        for (int i = 0; i < 17; i++) begin
            bytes[i] = 8'($urandom);
            set_push(bytes[i]);
            cyc();
        end
        set_bus(1'b0, 1'b1, 32'h0);
        cyc();
        checks++; if (o_wb_data !== 32'h9010) begin errors++; $display("FAIL ovf_status got=%h exp=00009010", o_wb_data); end
        for (int i = 0; i < 16; i++) begin
            set_bus(1'b0, 1'b0, 32'h0);
            cyc();
            checks++; if (o_wb_data !== {24'h0, bytes[i]}) begin errors++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, o_wb_data, {24'h0, bytes[i]}); end
        end
        set_bus(1'b1, 1'b1, 32'h1);
        cyc();
        set_bus(1'b0, 1'b1, 32'h0);
        cyc();
        checks++; if (o_wb_data !== 32'h0800) begin errors++; $display("FAIL ovf_cleared got=%h exp=00000800", o_wb_data); end
    endtask

    task automatic test_flags();
        set_push(8'h00);
        i_rx_ferr = 1'b1;
        cyc();
        set_push(8'hA5);
        i_rx_break = 1'b1;
        i_rx_perr  = 1'b1;
        cyc();
        set_bus(1'b0, 1'b0, 32'h0);
        cyc();
        checks++; if (o_wb_data !== 32'h400) begin errors++; $display("FAIL flags_ferr got=%h exp=00000400", o_wb_data); end
        set_bus(1'b0, 1'b0, 32'h0);
        cyc();
        checks++; if (o_wb_data !== 32'hAA5) begin errors++; $display("FAIL flags_brk_perr got=%h exp=00000aa5", o_wb_data); end
        // Writes to the data register are acknowledged but change nothing
        set_bus(1'b1, 1'b0, 32'hFFFF_FFFF);
        cyc();
        checks++; if (o_wb_ack !== 1'b1) begin errors++; $display("FAIL data_write_ack got=%b exp=1", o_wb_ack); end
        set_bus(1'b0, 1'b1, 32'h0);
        cyc();
        checks++; if (o_wb_data !== 32'h0800) begin errors++; $display("FAIL data_write_ignored got=%h exp=00000800", o_wb_data); end
    endtask

    task automatic test_rts_half();
        for (int k = 1; k <= 12; k++) begin
            set_push(8'(k));
            cyc();
            checks++; if (o_rts !== 1'b1) begin errors++; $display("FAIL rts_fill[%0d] got=%b exp=1", k, o_rts); end
            checks++; if (o_half_int !== (k - 1 >= 8)) begin errors++; $display("FAIL half_fill[%0d] got=%b exp=%b", k, o_half_int, (k - 1 >= 8)); end
        end
        cyc();
        checks++; if (o_rts !== 1'b0) begin errors++; $display("FAIL rts_at_12 got=%b exp=0", o_rts); end
        set_bus(1'b0, 1'b0, 32'h0);
        cyc();
        checks++; if (o_rts !== 1'b0) begin errors++; $display("FAIL rts_pop_edge got=%b exp=0", o_rts); end
        cyc();
        checks++; if (o_rts !== 1'b1) begin errors++; $display("FAIL rts_after_pop got=%b exp=1", o_rts); end
        drain();
    endtask

    task automatic test_full_push_pop();
        logic [7:0] bytes [16];
        logic [7:0] nb;
        for (int i = 0; i < 16; i++) begin
            bytes[i] = 8'($urandom);
            set_push(bytes[i]);
            cyc();
        end
        nb = 8'($urandom);
        set_push(nb);
        set_bus(1'b0, 1'b0, 32'h0);
        cyc();
        checks++; if (o_wb_data !== {24'h0, bytes[0]}) begin errors++; $display("FAIL fullpp_first got=%h exp=%h", o_wb_data, {24'h0, bytes[0]}); end
        set_bus(1'b0, 1'b1, 32'h0);
        cyc();
        checks++; if (o_wb_data !== 32'h1010) begin errors++; $display("FAIL fullpp_status got=%h exp=00001010", o_wb_data); end
        for (int i = 1; i < 17; i++) begin
            set_bus(1'b0, 1'b0, 32'h0);
            cyc();
            if (i < 16) begin
                checks++; if (o_wb_data !== {24'h0, bytes[i]}) begin errors++; $display("FAIL fullpp_data[%0d] got=%h exp=%h", i, o_wb_data, {24'h0, bytes[i]}); end
            end else begin
                checks++; if (o_wb_data !== {24'h0, nb}) begin errors++; $display("FAIL fullpp_last got=%h exp=%h", o_wb_data, {24'h0, nb}); end
            end
        end
    endtask

    task automatic test_back_to_back_empty();
        logic [7:0] b;
        b = 8'($urandom);
        set_push(b);
        set_bus(1'b0, 1'b0, 32'h0);
        cyc();
        checks++; if (o_wb_data !== 32'h100) begin errors++; $display("FAIL b2b_empty_read got=%h exp=00000100", o_wb_data); end
        set_bus(1'b0, 1'b1, 32'h0);
        cyc();
        checks++; if (o_wb_data !== 32'h0001) begin errors++; $display("FAIL b2b_status got=%h exp=00000001", o_wb_data); end
        set_bus(1'b0, 1'b0, 32'h0);
        cyc();
        checks++; if (o_wb_data !== {24'h0, b}) begin errors++; $display("FAIL b2b_data got=%h exp=%h", o_wb_data, {24'h0, b}); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            set_push(8'h80 + 8'(i));
            cyc();
        end
        set_bus(1'b0, 1'b0, 32'h0);
        cyc();
        // Read strobe pending when reset lands between edges
        set_bus(1'b0, 1'b0, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        checks++; if (o_wb_ack !== 1'b0) begin errors++; $display("FAIL arst_ack got=%b exp=0", o_wb_ack); end
        checks++; if (o_wb_data !== 32'h0) begin errors++; $display("FAIL arst_data got=%h exp=0", o_wb_data); end
        checks++; if (o_int !== 1'b0) begin errors++; $display("FAIL arst_int got=%b exp=0", o_int); end
        checks++; if (o_rts !== 1'b1) begin errors++; $display("FAIL arst_rts got=%b exp=1", o_rts); end
        @(posedge i_clk);
        #1;
        checks++; if (o_wb_ack !== 1'b0) begin errors++; $display("FAIL arst_ack_held got=%b exp=0", o_wb_ack); end
        model_reset();
        i_rst    = 1'b0;
        i_wb_stb = 1'b0;
        set_bus(1'b0, 1'b0, 32'h0);
        cyc();
        checks++; if (o_wb_data !== 32'h100) begin errors++; $display("FAIL arst_read_empty got=%h exp=00000100", o_wb_data); end
    endtask

    task automatic test_random();
        int phase;
        int rdp;
        int psp;
        int r;
        for (int i = 0; i < 800; i++) begin
            phase = (i / 64) % 2;
            psp   = phase ? 75 : 25;
            rdp   = phase ? 20 : 60;
            if ($urandom_range(0, 99) < psp) begin
                set_push(8'($urandom));
                i_rx_break = 1'($urandom_range(0, 7) == 0);
                i_rx_ferr  = 1'($urandom_range(0, 7) == 0);
                i_rx_perr  = 1'($urandom_range(0, 7) == 0);
            end
            r = $urandom_range(0, 99);
            if (r < rdp)            set_bus(1'b0, 1'b0, $urandom);
            else if (r < rdp + 6)   set_bus(1'b0, 1'b1, $urandom);
            else if (r < rdp + 8)   set_bus(1'b1, 1'b1, {30'h0, 2'($urandom_range(0, 3))});
            else if (r < rdp + 10)  set_bus(1'b1, 1'b0, $urandom);
            cyc();
            checks++; if (o_wb_ack !== m_ack) begin errors++; $display("FAIL rnd_ack[%0d] got=%b exp=%b", i, o_wb_ack, m_ack); end
            checks++; if (o_wb_data !== m_rdata) begin errors++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, o_wb_data, m_rdata); end
            checks++; if (o_int !== m_int) begin errors++; $display("FAIL rnd_int[%0d] got=%b exp=%b", i, o_int, m_int); end
            checks++; if (o_half_int !== m_half) begin errors++; $display("FAIL rnd_half[%0d] got=%b exp=%b", i, o_half_int, m_half); end
            checks++; if (o_rts !== m_rts) begin errors++; $display("FAIL rnd_rts[%0d] got=%b exp=%b", i, o_rts, m_rts); end
        end
    endtask

    initial begin
        i_rst      = 1'b1;
        i_rx_stb   = 1'b0;
        i_rx_data  = 8'h0;
        i_rx_break = 1'b0;
        i_rx_perr  = 1'b0;
        i_rx_ferr  = 1'b0;
        i_wb_stb   = 1'b0;
        i_wb_we    = 1'b0;
        i_wb_addr  = 1'b0;
        i_wb_data  = 32'h0;
        model_reset();

        test_reset();
        test_fifo_order();
        test_overflow();
        test_flags();
        test_rts_half();
        test_full_push_pop();
        test_back_to_back_empty();
        test_async_reset();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
